// File: rtl/egress_rr_scheduler_pkg.sv
// Shared widths, word field offsets and FSM encoding for the egress round-robin scheduler.
// Pure constants; no latency or flow control of its own.
package egress_rr_scheduler_pkg;

    localparam int DATA_W    = 12;
    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;

    localparam int CLASS_MSB = 11;
    localparam int CLASS_LSB = 10;
    localparam int DEST_MSB  = 9;
    localparam int DEST_LSB  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_CAPT = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/egress_rr_scheduler_rr_pick4.sv
// Combinational 4-way round-robin picker: first requester at or above i_ptr (mod 4).
// Zero latency; no flow control, o_any qualifies o_idx.
module rr_pick4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [1:0] o_idx,
    output logic       o_any
);

    always_comb begin
        logic [1:0] w_lane;
        o_any  = |i_req;
        o_idx  = i_ptr;
        w_lane = i_ptr;
        // Walk from the farthest offset down so the nearest requester wins last.
        for (int k = 3; k >= 0; k--) begin
            w_lane = i_ptr + 2'(k);
            if (i_req[w_lane]) begin
                o_idx = w_lane;
            end
        end
    end

endmodule

// File: rtl/egress_rr_scheduler.sv
// Drains lane FIFOs 4..7 round-robin into one valid/ready stream; 3 cycles min per word (POP, CAPT, SEND).
// Holds the word while ready_in is low; DEST_CHECK_EN drops words whose dest field disagrees with the lane.
module egress_rr_scheduler
    import egress_rr_scheduler_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_LANES-1:0]        empty,
    input  logic [NUM_LANES*DATA_W-1:0] lane_data,
    output logic [NUM_LANES-1:0]        pop,
    output logic [DATA_W-1:0]           data_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic [LANE_W-1:0]           lane_out,
    input  logic [LANE_W-1:0]           cnt_sel,
    output logic [CNT_W-1:0]            cnt_value,
    output logic                        idle,
    output logic                        err_dest
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LANE_W-1:0]   r_grant;
    logic [LANE_W-1:0]   r_ptr;
    logic [LANE_W-1:0]   r_lane;
    logic [DATA_W-1:0]   r_data;
    logic [CNT_W-1:0]    r_cnt [NUM_LANES];
    logic [LANE_W-1:0]   w_pick_idx;
    logic                w_pick_any;
    logic [DATA_W-1:0]   w_word;
    logic                w_accept;
    logic                w_dest_bad;

    rr_pick4 u_pick (
        .i_req (~empty),
        .i_ptr (r_ptr),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_word   = lane_data[r_grant*DATA_W +: DATA_W];
    assign w_accept = (r_state == ST_SEND) && ready_in;

`ifdef DEST_CHECK_EN
    logic r_err;

    assign w_dest_bad = (w_word[DEST_MSB:DEST_LSB] != r_grant);
    assign err_dest   = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (r_state == ST_CAPT && w_dest_bad) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_dest_bad = 1'b0;
    assign err_dest   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_pick_any) w_state_nxt = ST_POP;
            ST_POP:  w_state_nxt = ST_CAPT;
            ST_CAPT: w_state_nxt = w_dest_bad ? ST_IDLE : ST_SEND;
            ST_SEND: if (ready_in) w_state_nxt = w_pick_any ? ST_POP : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant <= '0;
            r_ptr   <= '0;
            r_lane  <= '0;
            r_data  <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if ((r_state == ST_IDLE || w_accept) && w_pick_any) begin
                r_grant <= w_pick_idx;
            end
            // Pointer advances even when the captured word is dropped.
            if (r_state == ST_CAPT) begin
                r_ptr <= r_grant + 2'd1;
                if (!w_dest_bad) begin
                    r_data <= w_word;
                    r_lane <= r_grant;
                end
            end
            if (w_accept) begin
                r_cnt[r_lane] <= r_cnt[r_lane] + CNT_W'(1);
            end
        end
    end

    assign pop       = (r_state == ST_POP) ? lane_onehot(r_grant) : '0;
    assign valid_out = (r_state == ST_SEND);
    assign data_out  = r_data;
    assign lane_out  = r_lane;
    assign cnt_value = r_cnt[cnt_sel];
    assign idle      = (r_state == ST_IDLE) && (&empty);

endmodule

// File: tb/tb_egress_rr_scheduler.sv
// Directed bench for egress_rr_scheduler with a 1-cycle-latency lane FIFO model and an acceptance log.
module tb_egress_rr_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  empty;
    logic [47:0] lane_data = '0;
    logic [3:0]  pop;
    logic [11:0] data_out;
    logic        valid_out;
    logic        ready_in;
    logic [1:0]  lane_out;
    logic [1:0]  cnt_sel;
    logic [4:0]  cnt_value;
    logic        idle;
    logic        err_dest;

    int n_chk  = 0;
    int n_fail = 0;

    logic [11:0] mem [4][64];
    int          wr_ptr [4] = '{default: 0};
    int          rd_ptr [4] = '{default: 0};
    int          cyc = 0;
    int          pop_bad = 0;
    logic [11:0] acc_dat [$];
    logic [1:0]  acc_lane [$];
    int          acc_cyc [$];

    always #5 clk = ~clk;

    egress_rr_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .empty     (empty),
        .lane_data (lane_data),
        .pop       (pop),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .lane_out  (lane_out),
        .cnt_sel   (cnt_sel),
        .cnt_value (cnt_value),
        .idle      (idle),
        .err_dest  (err_dest)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
        end
    end

    // Lane FIFO model: data appears on lane_data the cycle after pop.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (pop[i]) begin
                lane_data[i*12 +: 12] <= mem[i][rd_ptr[i] % 64];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
        if (pop != 4'b0000 && ($countones(pop) != 1 || (pop & empty) != 4'b0000)) begin
            pop_bad <= pop_bad + 1;
        end
        if (valid_out && ready_in) begin
            acc_dat.push_back(data_out);
            acc_lane.push_back(lane_out);
            acc_cyc.push_back(cyc);
        end
    end

    task automatic push(input int lane, input logic [11:0] w);
        mem[lane][wr_ptr[lane] % 64] = w;
        wr_ptr[lane] = wr_ptr[lane] + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) wr_ptr[i] = rd_ptr[i];
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_acc(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            if (acc_dat.size() >= target) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (valid_out) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        ready_in = 1'b1;
        cnt_sel  = 2'd0;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (pop !== 4'b0000) begin n_fail++; $display("FAIL reset_pop: got %b expected 0000", pop); end
        n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle); end
        n_chk++; if (data_out !== 12'h000) begin n_fail++; $display("FAIL reset_data: got %h expected 000", data_out); end
        n_chk++; if (lane_out !== 2'd0) begin n_fail++; $display("FAIL reset_lane: got %0d expected 0", lane_out); end
        n_chk++; if (err_dest !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_dest); end
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1;
            n_chk++; if (cnt_value !== 5'd0) begin n_fail++; $display("FAIL reset_cnt%0d: got %0d expected 0", s, cnt_value); end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_lane();
        @(negedge clk);
        push(2, 12'h2A5);
        @(negedge clk);
        n_chk++; if (pop !== 4'b0100) begin n_fail++; $display("FAIL single_pop: got %b expected 0100", pop); end
        @(negedge clk);
        n_chk++; if (pop !== 4'b0000 || valid_out !== 1'b0) begin n_fail++; $display("FAIL single_capt: got pop=%b valid=%b expected 0000/0", pop, valid_out); end
        @(negedge clk);
        n_chk++; if (valid_out !== 1'b1 || data_out !== 12'h2A5 || lane_out !== 2'd2) begin
            n_fail++; $display("FAIL single_send: got v=%b d=%h l=%0d expected 1/2a5/2", valid_out, data_out, lane_out); end
        @(negedge clk);
        cnt_sel = 2'd2;
        #1;
        n_chk++; if (valid_out !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL single_drop: got v=%b idle=%b expected 0/1", valid_out, idle); end
        n_chk++; if (cnt_value !== 5'd1) begin n_fail++; $display("FAIL single_cnt: got %0d expected 1", cnt_value); end
    endtask

    task automatic test_round_robin();
        int          base;
        bit          ok;
        logic [11:0] w;
        do_reset();
        base = acc_dat.size();
        for (int r = 0; r < 2; r++)
            for (int l = 0; l < 4; l++) push(l, {2'b01, 2'(l), 8'(16 * r + l)});
        wait_acc(base + 8, 60, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d words expected 8", acc_dat.size() - base); end
        for (int k = 0; k < 8; k++) begin
            w = {2'b01, 2'(k % 4), 8'(16 * (k / 4) + k % 4)};
            n_chk++; if (acc_lane[base+k] !== 2'(k % 4) || acc_dat[base+k] !== w) begin
                n_fail++; $display("FAIL rr_word%0d: got lane %0d data %h expected lane %0d data %h", k, acc_lane[base+k], acc_dat[base+k], k % 4, w); end
            if (k > 0) begin
                n_chk++; if (acc_cyc[base+k] - acc_cyc[base+k-1] !== 3) begin
                    n_fail++; $display("FAIL rr_spacing%0d: got %0d expected 3", k, acc_cyc[base+k] - acc_cyc[base+k-1]); end
            end
        end
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1;
            n_chk++; if (cnt_value !== 5'd2) begin n_fail++; $display("FAIL rr_cnt%0d: got %0d expected 2", s, cnt_value); end
        end
    endtask

    task automatic test_backpressure();
        int base;
        bit ok;
        @(negedge clk);
        ready_in = 1'b0;
        cnt_sel  = 2'd1;
        base     = acc_dat.size();
        push(1, 12'h5A1);
        push(3, 12'h3F3);
        wait_valid(10, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got no valid_out expected valid"); end
        for (int c = 0; c < 5; c++) begin
            n_chk++; if (valid_out !== 1'b1 || data_out !== 12'h5A1 || lane_out !== 2'd1 || pop !== 4'b0000 || cnt_value !== 5'd2) begin
                n_fail++; $display("FAIL bp_hold%0d: got v=%b d=%h l=%0d pop=%b cnt=%0d expected 1/5a1/1/0000/2",
                                   c, valid_out, data_out, lane_out, pop, cnt_value); end
            @(negedge clk);
        end
        ready_in = 1'b1;
        @(negedge clk);
        n_chk++; if (cnt_value !== 5'd3 || pop !== 4'b1000) begin
            n_fail++; $display("FAIL bp_accept: got cnt=%0d pop=%b expected 3/1000", cnt_value, pop); end
        wait_acc(base + 2, 20, ok);
        repeat (4) @(negedge clk);
        n_chk++; if (acc_dat.size() !== base + 2 || acc_dat[base] !== 12'h5A1 || acc_dat[base+1] !== 12'h3F3) begin
            n_fail++; $display("FAIL bp_words: got n=%0d %h %h expected 2 5a1 3f3", acc_dat.size() - base, acc_dat[base], acc_dat[base+1]); end
        n_chk++; if (cnt_value !== 5'd3) begin n_fail++; $display("FAIL bp_cnt1: got %0d expected 3", cnt_value); end
        cnt_sel = 2'd3;
        #1;
        n_chk++; if (cnt_value !== 5'd3) begin n_fail++; $display("FAIL bp_cnt3: got %0d expected 3", cnt_value); end
    endtask

    task automatic test_wrap_and_async_reset();
        int base;
        bit ok;
        do_reset();
        base = acc_dat.size();
        for (int k = 0; k < 33; k++) push(0, {2'b10, 2'b00, 8'(k)});
        wait_acc(base + 33, 33 * 3 + 20, ok);
        cnt_sel = 2'd0;
        #1;
        n_chk++; if (!ok || cnt_value !== 5'd1) begin n_fail++; $display("FAIL wrap_cnt0: got %0d ok=%b expected 1", cnt_value, ok); end
        push(0, 12'h8FF);
        wait_valid(10, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout: got no valid_out expected valid"); end
        reset = 1'b0;
        #1;
        n_chk++; if (valid_out !== 1'b0 || data_out !== 12'h000 || lane_out !== 2'd0 || pop !== 4'b0000) begin
            n_fail++; $display("FAIL async_outs: got v=%b d=%h l=%0d pop=%b expected 0/000/0/0000", valid_out, data_out, lane_out, pop); end
        n_chk++; if (cnt_value !== 5'd0 || idle !== 1'b1) begin
            n_fail++; $display("FAIL async_state: got cnt=%0d idle=%b expected 0/1", cnt_value, idle); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_dest_check();
        int base;
        bit ok;
        do_reset();
        ready_in = 1'b1;
        cnt_sel  = 2'd1;
        base     = acc_dat.size();
        push(1, 12'h344);
        push(1, 12'h155);
`ifdef DEST_CHECK_EN
        wait_acc(base + 1, 30, ok);
        repeat (6) @(negedge clk);
        n_chk++; if (!ok || acc_dat.size() !== base + 1 || acc_dat[base] !== 12'h155 || acc_lane[base] !== 2'd1) begin
            n_fail++; $display("FAIL dest_drop: got n=%0d d=%h l=%0d expected 1/155/1", acc_dat.size() - base, acc_dat[base], acc_lane[base]); end
        n_chk++; if (err_dest !== 1'b1) begin n_fail++; $display("FAIL dest_err: got %b expected 1", err_dest); end
        n_chk++; if (cnt_value !== 5'd1) begin n_fail++; $display("FAIL dest_cnt: got %0d expected 1", cnt_value); end
`else
        wait_acc(base + 2, 30, ok);
        n_chk++; if (!ok || acc_dat[base] !== 12'h344 || acc_dat[base+1] !== 12'h155) begin
            n_fail++; $display("FAIL nodest_words: got %h %h expected 344 155", acc_dat[base], acc_dat[base+1]); end
        n_chk++; if (err_dest !== 1'b0) begin n_fail++; $display("FAIL nodest_err: got %b expected 0", err_dest); end
        n_chk++; if (cnt_value !== 5'd2) begin n_fail++; $display("FAIL nodest_cnt: got %0d expected 2", cnt_value); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_round_robin();
        test_backpressure();
        test_wrap_and_async_reset();
        test_dest_check();
        n_chk++; if (pop_bad !== 0) begin n_fail++; $display("FAIL pop_legal: got %0d bad pops expected 0", pop_bad); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/egress_rr_scheduler.md
Name: egress_rr_scheduler

Overview:
Downstream drain stage for the four output FIFOs (lanes 4..7) of the PCIE switch.
- Pops the lane FIFOs one word at a time in round-robin order.
- Merges the words into a single 12-bit valid/ready stream toward the sink.
- Keeps per-lane delivered-word counters, readable through a select/read port.

Parameters:
DATA_W, 12, word width; [11:10] class, [9:8] dest, [7:0] payload
CNT_W, 5, width of each per-lane delivered counter

Ports:
clk  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
empty  in  4  empty flags of lane FIFOs 4..7 (bit i = lane i)
lane_data  in  4*DATA_W  packed FIFO data_out; lane i at [i*DATA_W +: DATA_W]
pop  out  4  one-hot FIFO read enable, to lane FIFO read_enable
data_out  out  DATA_W  merged output word
valid_out  out  1  data_out holds a word
ready_in  in  1  sink accepts the word when valid_out && ready_in
lane_out  out  2  source lane of current data_out
cnt_sel  in  2  selects lane counter for cnt_value
cnt_value  out  CNT_W  delivered-word count of selected lane (combinational read)
idle  out  1  FSM in IDLE and all empty bits high
err_dest  out  1  sticky dest-mismatch flag (DEST_CHECK_EN only; else tied 0)

Behaviour:
- Reset (reset=0, async) clears all state:
  - pop=0, data_out=0, valid_out=0, lane_out=0.
  - All counters 0; RR pointer = lane 0; err_dest=0; state = IDLE.
  - A word popped but not yet delivered is lost.
- Lane FIFO read latency is 1 cycle: pop[i] high in cycle N means lane_data lane i is valid in cycle N+1.
- FSM states IDLE, POP, CAPT, SEND.
  - IDLE:
    - If any empty[i]=0, pick the first non-empty lane searching from the RR pointer upward (mod 4).
    - Latch it as grant; go to POP.
    - Otherwise stay in IDLE.
  - POP: pop = one-hot(grant) for exactly this cycle; go to CAPT.
  - CAPT:
    - Register lane_data[grant] into data_out; lane_out = grant.
    - valid_out goes high from the next cycle.
    - RR pointer = grant+1 (mod 4); go to SEND.
  - SEND:
    - valid_out=1; data_out and lane_out are held stable while ready_in=0.
    - On ready_in=1: increment counter[lane_out] (wraps 2^CNT_W-1 -> 0).
      - If some empty bit is low, choose next grant as in IDLE and go to POP.
      - Else go to IDLE.
    - valid_out drops the cycle after acceptance unless reloaded via CAPT.
- pop is never asserted outside POP; at most one bit high; never asserted for a lane whose empty was high at grant time.
- Minimum spacing between accepted words: 3 cycles (POP, CAPT, SEND).
- Empty changes after grant do not cancel the pop.
- idle is a combinational function of state and empty.

Optional Feature:
DEST_CHECK_EN
- Defined:
  - In CAPT, compare word[9:8] with grant.
  - On mismatch: set err_dest (sticky until reset), drop the word (no SEND, no count increment), and go to IDLE with the RR pointer still advanced.
- Undefined: no check; err_dest is constant 0; every popped word is delivered.

Decomposition:
- Shared package: DATA_W, field offsets (CLASS_MSB/LSB, DEST_MSB/LSB), FSM state encoding constants, NUM_LANES=4.
- One sub-module: rr_pick4, a combinational 4-way round-robin priority picker. Inputs: request vector, pointer. Outputs: grant index and any.

Test Plan:
1. Reset with all empty=1 -> pop=0, valid_out=0, idle=1, cnt_value=0 for all cnt_sel.
2. Lane 2 only non-empty (empty=4'b1011), word 12'h2A5, ready_in=1 -> pop=4'b0100 for one cycle; two cycles later data_out=12'h2A5, lane_out=2; cnt_value(sel=2)=1.
3. All lanes non-empty, ready_in=1, 8 words -> pop order 0,1,2,3,0,1,2,3; each counter reads 2.
4. ready_in=0 for 5 cycles during SEND -> data_out and lane_out stable, no pop, no count change; on ready_in=1 the word is counted once.
5. Deliver 33 words on lane 0 -> cnt_value(sel=0)=1 (wrap at 32); assert reset mid-SEND -> all outputs 0 and counters cleared immediately.
6. DEST_CHECK_EN: lane 1 supplies a word with dest=2'b11 -> err_dest=1, valid_out stays 0, counter1 unchanged; next valid word on lane 1 is delivered normally.
